// File: rtl/writeback_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage_if
// Brief    : Bundle of writeback-stage instruction inputs and register-file
//            write-port outputs. The producer (pipeline / bench) drives through
//            the master modport; the writeback stage consumes through slave.
// Revision : 1.0  initial release
// ============================================================================
interface writeback_stage_if;
  // Instruction side, driven by the memory stage
  logic        writeback_enable;
  logic        mem_read_enable;
  logic [3:0]  instruction_dest;
  logic [23:0] mem_read_data;
  logic [23:0] alu_result;

  // Register-file write port, driven by the writeback stage
  logic        writeback_enable_out;
  logic [3:0]  instruction_dest_out;
  logic [23:0] writeback_data_out;

  modport master (
    output writeback_enable,
    output mem_read_enable,
    output instruction_dest,
    output mem_read_data,
    output alu_result,
    input  writeback_enable_out,
    input  instruction_dest_out,
    input  writeback_data_out
  );

  modport slave (
    input  writeback_enable,
    input  mem_read_enable,
    input  instruction_dest,
    input  mem_read_data,
    input  alu_result,
    output writeback_enable_out,
    output instruction_dest_out,
    output writeback_data_out
  );
endinterface
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Brief    : Final pipeline stage. Selects load data or ALU result, qualifies
//            the register-file write strobe and registers the write port with
//            exactly one cycle of latency. Idle cycles present an all-zero
//            write port (strobe, address and data all cleared).
// Config   : WB_R0_GUARD_EN - when defined, writes to register index 0 are
//            suppressed and look like an idle cycle.
// Revision : 1.0  initial release
// ============================================================================
module writeback_stage (
  input  logic             clk,
  input  logic             rst_n,
  writeback_stage_if.slave wb
);

  localparam logic [3:0]  c_dest_idle = 4'd0;
  localparam logic [23:0] c_data_idle = 24'd0;

  logic        w_wb_eff;
  logic [23:0] w_sel_data;

  logic        r_wb_en;
  logic [3:0]  r_wb_dest;
  logic [23:0] r_wb_data;

  // A load implies a register write even if the ALU-write flag is clear.
`ifdef WB_R0_GUARD_EN
  assign w_wb_eff = (wb.writeback_enable | wb.mem_read_enable) &
                    (wb.instruction_dest != c_dest_idle);
`else
  assign w_wb_eff = wb.writeback_enable | wb.mem_read_enable;
`endif

  // Load data wins over the ALU result when both enables are set.
  assign w_sel_data = wb.mem_read_enable ? wb.mem_read_data : wb.alu_result;

  // Output register: capture a qualified write, otherwise clear the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_en   <= 1'b0;
      r_wb_dest <= c_dest_idle;
      r_wb_data <= c_data_idle;
    end else if (w_wb_eff) begin
      r_wb_en   <= 1'b1;
      r_wb_dest <= wb.instruction_dest;
      r_wb_data <= w_sel_data;
    end else begin
      r_wb_en   <= 1'b0;
      r_wb_dest <= c_dest_idle;
      r_wb_data <= c_data_idle;
    end
  end

  assign wb.writeback_enable_out = r_wb_en;
  assign wb.instruction_dest_out = r_wb_dest;
  assign wb.writeback_data_out   = r_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_stage
// Brief    : Self-checking bench for writeback_stage: directed vector table
//            streamed back-to-back through a scoreboard queue, hand-written
//            reset sequences, and a short random stream.
// Revision : 1.0  initial release
// ============================================================================
module tb_writeback_stage;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  writeback_stage_if bus ();

  writeback_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus.slave)
  );

  typedef struct {
    logic        wb;
    logic        mr;
    logic [3:0]  dest;
    logic [23:0] mem;
    logic [23:0] alu;
    logic        exp_en;
    logic [3:0]  exp_dest;
    logic [23:0] exp_data;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs [NVEC];

  logic [28:0] exp_q [$];
  logic [28:0] last_exp;
  int n_vec = 0;
  int n_err = 0;

  // Compare the write port against one expected {en, dest, data} word.
  task automatic check(input string nm, input logic [28:0] exp);
    logic [28:0] act;
    act = {bus.writeback_enable_out, bus.instruction_dest_out, bus.writeback_data_out};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got en=%0b dest=%0d data=%06h, expected en=%0b dest=%0d data=%06h",
               nm, act[28], act[27:24], act[23:0], exp[28], exp[27:24], exp[23:0]);
    end
  endtask

  task automatic drive(input logic w, input logic m, input logic [3:0] d,
                       input logic [23:0] md, input logic [23:0] a);
    bus.writeback_enable = w;
    bus.mem_read_enable  = m;
    bus.instruction_dest = d;
    bus.mem_read_data    = md;
    bus.alu_result       = a;
  endtask

  // Reference behaviour of one instruction, straight from the requirements.
  function automatic logic [28:0] model(input logic w, input logic m, input logic [3:0] d,
                                        input logic [23:0] md, input logic [23:0] a);
    logic eff;
    eff = w || m;
`ifdef WB_R0_GUARD_EN
    if (d == 4'd0) eff = 1'b0;
`endif
    if (!eff) return 29'd0;
    return {1'b1, d, (m ? md : a)};
  endfunction

  task automatic pop_check(input string nm);
    logic [28:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty, expected an entry", nm);
    end else begin
      e = exp_q.pop_front();
      check(nm, e);
      last_exp = e;
    end
  endtask

  initial begin
    // idle / ALU write / load / priority+boundary / idle with junk inputs
    vecs[0] = '{1'b0, 1'b0, 4'd0,  24'h000000, 24'h000000, 1'b0, 4'd0,  24'h000000};
    vecs[1] = '{1'b1, 1'b0, 4'd1,  24'h000000, 24'h000001, 1'b1, 4'd1,  24'h000001};
    vecs[2] = '{1'b0, 1'b1, 4'd2,  24'h000002, 24'h000001, 1'b1, 4'd2,  24'h000002};
    vecs[3] = '{1'b1, 1'b1, 4'd15, 24'hFFFFFF, 24'h000001, 1'b1, 4'd15, 24'hFFFFFF};
    vecs[4] = '{1'b0, 1'b0, 4'd7,  24'h5A5A5A, 24'hA5A5A5, 1'b0, 4'd0,  24'h000000};
`ifdef WB_R0_GUARD_EN
    vecs[5] = '{1'b1, 1'b0, 4'd0,  24'h111111, 24'h00ABCD, 1'b0, 4'd0,  24'h000000};
    vecs[8] = '{1'b0, 1'b1, 4'd0,  24'h123456, 24'h654321, 1'b0, 4'd0,  24'h000000};
`else
    vecs[5] = '{1'b1, 1'b0, 4'd0,  24'h111111, 24'h00ABCD, 1'b1, 4'd0,  24'h00ABCD};
    vecs[8] = '{1'b0, 1'b1, 4'd0,  24'h123456, 24'h654321, 1'b1, 4'd0,  24'h123456};
`endif
    vecs[6] = '{1'b1, 1'b0, 4'd15, 24'h000000, 24'hFFFFFF, 1'b1, 4'd15, 24'hFFFFFF};
    vecs[7] = '{1'b0, 1'b1, 4'd8,  24'h800000, 24'h7FFFFF, 1'b1, 4'd8,  24'h800000};

    // Reset held from time zero with a live write on the inputs.
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 4'd5, 24'h000000, 24'h123456);
    #3;
    check("reset_immediate", 29'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_held", 29'd0);

    // Release reset and stream the vector table back-to-back.
    rst_n    = 1'b1;
    last_exp = 29'd0;
    for (int i = 0; i < NVEC; i++) begin
      if (i != 0) begin
        @(negedge clk);
        pop_check($sformatf("vec%0d", i - 1));
      end
      drive(vecs[i].wb, vecs[i].mr, vecs[i].dest, vecs[i].mem, vecs[i].alu);
      exp_q.push_back({vecs[i].exp_en, vecs[i].exp_dest, vecs[i].exp_data});
      #1;
      check($sformatf("vec%0d_pre_edge", i), last_exp);
    end
    @(negedge clk);
    pop_check($sformatf("vec%0d", NVEC - 1));

    // Mid-cycle reset discards a pending write and clears the port at once.
    drive(1'b1, 1'b0, 4'd9, 24'h000000, 24'h777777);
    @(negedge clk);
    check("pre_reset_write", {1'b1, 4'd9, 24'h777777});
    drive(1'b0, 1'b1, 4'd3, 24'h00BEEF, 24'h000000);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", 29'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_no_strobe", 29'd0);
    rst_n = 1'b1;
    #1;
    check("release_pre_edge", 29'd0);
    @(negedge clk);
    check("first_edge_after_reset", {1'b1, 4'd3, 24'h00BEEF});

    // Random back-to-back stream through the scoreboard.
    exp_q.delete();
    last_exp = {1'b1, 4'd3, 24'h00BEEF};
    for (int i = 0; i < 24; i++) begin
      logic w, m;
      logic [3:0] d;
      logic [23:0] md, a;
      if (i != 0) begin
        @(negedge clk);
        pop_check($sformatf("rnd%0d", i - 1));
      end
      w  = 1'($urandom_range(0, 1));
      m  = 1'($urandom_range(0, 1));
      d  = 4'($urandom_range(0, 15));
      md = 24'($urandom);
      a  = 24'($urandom);
      drive(w, m, d, md, a);
      exp_q.push_back(model(w, m, d, md, a));
    end
    @(negedge clk);
    pop_check("rnd23");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
